// File: rtl/pixel_pkg.sv
// Shared constants, FSM encoding and stream beat layout for the frame pixel streamer.
package pixel_pkg;

  localparam int WIDTH      = 28;
  localparam int HEIGHT     = 28;
  localparam int NUM_PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W     = 10;
  localparam int ROW_W      = 5;
  localparam int COL_W      = 5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]       data;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             first;
    logic             last;
  } beat_t;

endpackage

// File: rtl/pixel_beat_fifo.sv
// Small synchronous first-word-fall-through FIFO of stream beats; the head is
// visible whenever the FIFO holds data, and push/pop may coincide even when full.
module pixel_beat_fifo
  import pixel_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  beat_t            i_beat,
  input  logic             i_pop,
  output logic             o_valid,
  output beat_t            o_beat,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  beat_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // NOTE: the storage array is deliberately not reset; the head output is
  // forced to zero while empty, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_beat;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_beat  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/frame_pixel_streamer.sv
// Reads a stored frame in raster order from the frame buffer's synchronous read
// port and presents it as a valid/ready pixel stream with coordinates and markers.
module frame_pixel_streamer
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              bit_clk,
  input  logic              rst,
  input  logic              frame_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [7:0]        px_data,
  output logic [ROW_W-1:0]  px_row,
  output logic [COL_W-1:0]  px_col,
  output logic              px_first,
  output logic              px_last,
  output logic              busy,
  output logic              frame_consumed,
  output logic              overrun
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ROW_W-1:0]  r_iss_row;
  logic [COL_W-1:0]  r_iss_col;
  logic              r_inflight;
  logic [ROW_W-1:0]  r_fl_row;
  logic [COL_W-1:0]  r_fl_col;
  logic              r_fl_first;
  logic              r_fl_last;
  logic              r_busy;
  logic              r_frame_consumed;
  logic              r_overrun;

  logic              w_pop;
  logic              w_issue;
  logic              w_fifo_valid;
  beat_t             w_head;
  beat_t             w_push_beat;
  logic [CNT_W-1:0]  w_fifo_count;

  assign w_pop = w_fifo_valid && px_ready;

  // A read is issued only if its data is guaranteed a FIFO slot when it
  // returns next cycle, counting the read already in flight and this cycle's pop.
  // NOTE: every always_comb output is fully assigned on all paths, so no
  // latch can be inferred.
  always_comb begin
    w_issue = (r_state == ST_READ) && !rst &&
              (int'(w_fifo_count) + int'(r_inflight) < FIFO_DEPTH + int'(w_pop));
  end

  always_comb begin
    w_push_beat = '{data: rd_data, row: r_fl_row, col: r_fl_col,
                    first: r_fl_first, last: r_fl_last};
  end

  always_ff @(posedge bit_clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_rd_addr        <= '0;
      r_iss_row        <= '0;
      r_iss_col        <= '0;
      r_inflight       <= 1'b0;
      r_fl_row         <= '0;
      r_fl_col         <= '0;
      r_fl_first       <= 1'b0;
      r_fl_last        <= 1'b0;
      r_busy           <= 1'b0;
      r_frame_consumed <= 1'b0;
      r_overrun        <= 1'b0;
    end else begin
      r_frame_consumed <= 1'b0;
      r_inflight       <= w_issue;

      // The consumed cycle still counts as busy for incoming frame_done pulses.
      if (frame_done && (r_state != ST_IDLE || r_frame_consumed)) r_overrun <= 1'b1;

      if (w_issue) begin
        r_fl_row   <= r_iss_row;
        r_fl_col   <= r_iss_col;
        r_fl_first <= (r_rd_addr == '0);
        r_fl_last  <= (r_rd_addr == LAST_ADDR);
        if (r_rd_addr == LAST_ADDR) begin
          r_rd_addr <= '0;
          r_iss_row <= '0;
          r_iss_col <= '0;
        end else begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
          if (r_iss_col == LAST_COL) begin
            r_iss_col <= '0;
            r_iss_row <= r_iss_row + ROW_W'(1);
          end else begin
            r_iss_col <= r_iss_col + COL_W'(1);
          end
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (frame_done && !r_frame_consumed) begin
            r_state <= ST_READ;
            r_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          if (w_issue && r_rd_addr == LAST_ADDR) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_pop && w_head.last) begin
            r_state          <= ST_IDLE;
            r_busy           <= 1'b0;
            r_frame_consumed <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pixel_beat_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (bit_clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_beat  (w_push_beat),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_beat  (w_head),
    .o_count (w_fifo_count)
  );

  assign rd_en          = w_issue;
  assign rd_addr        = r_rd_addr;
  assign px_valid       = w_fifo_valid;
  assign px_data        = w_head.data;
  assign px_row         = w_head.row;
  assign px_col         = w_head.col;
  assign px_first       = w_head.first;
  assign px_last        = w_head.last;
  assign busy           = r_busy;
  assign frame_consumed = r_frame_consumed;
  assign overrun        = r_overrun;

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
Downstream consumer of the serial pixel frame buffer. On the buffer's frame_done pulse it reads all pixels of the frame in raster order through the buffer's synchronous read port and presents them to the inference datapath as a valid/ready stream. Each beat carries row/column coordinates and first/last markers. The block absorbs the RAM's 1-cycle read latency and downstream backpressure with a small output FIFO, and runs in the bit_clk domain shared with the buffer's read port.

Parameters:
WIDTH, 28, pixels per row
HEIGHT, 28, rows per frame
NUM_PIXELS, WIDTH*HEIGHT, pixels per frame (784)
ADDR_W, 10, read address width; must satisfy 2^ADDR_W >= NUM_PIXELS
FIFO_DEPTH, 2, output FIFO entries; minimum 2

Ports:
bit_clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
frame_done  in  1  1-cycle pulse from the frame buffer: a full frame is stored
rd_en  out  1  frame buffer read enable
rd_addr  out  ADDR_W  frame buffer read address, 0..NUM_PIXELS-1
rd_data  in  8  frame buffer read data, valid the cycle after rd_en
px_valid  out  1  stream beat valid
px_ready  in  1  downstream accepts the beat when px_valid && px_ready
px_data  out  8  pixel value
px_row  out  5  row index 0..HEIGHT-1
px_col  out  5  column index 0..WIDTH-1
px_first  out  1  beat is pixel 0
px_last  out  1  beat is pixel NUM_PIXELS-1
busy  out  1  high from frame start until the last beat is accepted
frame_consumed  out  1  1-cycle pulse in the cycle after the last beat is accepted
overrun  out  1  sticky: frame_done arrived while busy; cleared only by rst

Behaviour:
- Reset values: rd_en=0, rd_addr=0, px_valid=0, px_data/px_row/px_col=0, px_first=px_last=0, busy=0, frame_consumed=0, overrun=0. FIFO is emptied and any in-flight read is discarded.
- FSM states:
  - IDLE: on frame_done, go to READ; busy=1 from the next cycle.
  - READ: issue reads at addresses 0..NUM_PIXELS-1. After the last address is issued, go to DRAIN.
  - DRAIN: when the last beat (px_last) is accepted, go to IDLE. Pulse frame_consumed for 1 cycle and drop busy in the same cycle.
- Read issue rule: rd_en=1 in a cycle only if in READ and (fifo_count + inflight - pop) < FIFO_DEPTH. inflight is 1 if rd_en was high in the previous cycle; pop is px_valid && px_ready. rd_addr increments by 1 per issued read and returns to 0 when the frame ends.
- rd_data is written into the FIFO in the cycle after rd_en, together with coordinates and first/last flags tracked on the issue side.
  - Column wraps at WIDTH-1 back to 0 and increments the row.
- Latency: frame_done in cycle t -> rd_en cycle t+1 (addr 0) -> rd_data cycle t+2 -> px_valid cycle t+3.
- Throughput: with px_ready held high and depth 2, 1 beat/cycle sustained. A frame takes NUM_PIXELS+3 cycles from frame_done to frame_consumed.
- Stream rules: once px_valid is high, px_data/row/col/first/last are held stable until accepted. px_valid never drops without a handshake, except on rst.
- FIFO: push and pop may occur in the same cycle, including when the FIFO is full. It never overflows, by the issue rule. FIFO output is registered-valid (first-word-fall-through).
- frame_done while busy (including in the frame_consumed cycle): set overrun and ignore the pulse; the current frame continues unchanged.
- frame_done in IDLE while overrun=1: start normally; overrun stays set.
- rst mid-frame: immediate return to IDLE with the reset values above. No frame_consumed pulse.

Decomposition:
- Shared package pixel_pkg: WIDTH, HEIGHT, NUM_PIXELS, ADDR_W constants; FSM state encoding (IDLE, READ, DRAIN); stream beat struct {data[7:0], row[4:0], col[4:0], first, last}.
- One sub-module: pixel_beat_fifo, a synchronous first-word-fall-through FIFO of beat structs, parameterised by FIFO_DEPTH, with count output.

Test Plan:
- Reset then a single frame_done with the buffer preloaded to mem[i]=i[7:0] and px_ready=1 -> rd_en at t+1, first beat at t+3 with data 0, row 0, col 0, first=1. Beats 0..783 arrive on consecutive cycles; beat 27 is row 0 col 27, beat 28 is row 1 col 0. Beat 783 is row 27 col 27, data 0x0F, last=1. frame_consumed at t+787 and busy falls at the same time.
- Random px_ready (50%) -> exactly 784 beats, in order, no duplicates or drops. Outputs stay stable while valid && !ready. rd_en is never asserted while fifo_count+inflight-pop >= 2.
- px_ready held low for 100 cycles at start -> exactly 2 reads issued (addr 0, 1), then rd_en=0. On release, a stall-free stream resumes from data 0.
- frame_done at beat 400 -> overrun=1; stream completes exactly 784 beats with a single frame_consumed. A following frame_done in IDLE streams normally and overrun remains 1.
- rst asserted at beat 200 -> next cycle px_valid=0, busy=0, rd_en=0, overrun=0, and no frame_consumed. A later frame_done restarts at addr 0.
- frame_done in the same cycle as frame_consumed -> treated as busy: overrun=1 and no new frame starts.
